// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioning chain.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    // Bits needed to hold 0..n; a zero-length count still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous board input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Raw push-button pin to debounced level plus press/release/long-press pulses.
//
// state        | meaning
// IDLE         | released and stable
// PRESS_WAIT   | pressed samples seen, counting towards acceptance
// PRESSED      | pressed and stable
// RELEASE_WAIT | released samples seen, counting towards acceptance
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_COUNT = 1000000,
    parameter int unsigned LONG_COUNT     = 50000000,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned    CW        = cnt_width(DEBOUNCE_COUNT);
    localparam int unsigned    LW        = cnt_width(LONG_COUNT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_COUNT - 1);
    localparam logic [LW-1:0]  LONG_LAST = (LONG_COUNT > 0) ? LW'(LONG_COUNT - 1) : '0;
    localparam logic [LW-1:0]  LONG_MAX  = LW'(LONG_COUNT);

    logic            pin_sync;
    logic            btn_s;
    btn_state_e      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            level_nxt, press_nxt, release_nxt;
    logic [LW-1:0]   lcnt;

    sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (pin_sync)
    );

    assign btn_s = pin_sync ^ ACTIVE_LOW;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt     = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    // lcnt is held at zero while released, so the press edge always starts it from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt     <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (!btn_level) begin
                lcnt <= '0;
            end else if (lcnt != LONG_MAX) begin
                lcnt <= lcnt + LW'(1);
            end
            if ((LONG_COUNT != 0) && btn_level && (lcnt == LONG_LAST)) begin
                btn_long <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: stimulus table, timing sequences and random pin activity against a run-length model.
module tb_btn_debounce;

    localparam int DC = 4;
    localparam int LC = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b1;
    logic btn_level, btn_press, btn_release, btn_long;

    int tests = 0;
    int fails = 0;

    btn_debounce #(
        .DEBOUNCE_COUNT (DC),
        .LONG_COUNT     (LC),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    // Reference model: pin delayed two clocks, level flips after DC consecutive
    // samples disagreeing with it, long pulse LC clocks into a held level.
    logic m_p1 = 1'b1, m_p2 = 1'b1, m_s = 1'b0, m_old = 1'b0;
    logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_long = 1'b0;
    int   m_run = 0, m_since = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1 = 1'b1; m_p2 = 1'b1;
            m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
            m_run = 0; m_since = 0;
        end else begin
            m_s  = ~m_p2;
            m_p2 = m_p1;
            m_p1 = btn_in;
            m_old = m_level;
            m_press = 1'b0;
            m_release = 1'b0;
            if (m_s != m_level) m_run++;
            else m_run = 0;
            if (m_run == DC) begin
                m_level   = m_s;
                m_press   = m_s;
                m_release = ~m_s;
                m_run     = 0;
            end
            if (!m_old) m_since = 0;
            else m_since++;
            m_long = m_old && (m_since == LC);
        end
    end

    always @(negedge clk) begin
        tests++;
        if ({btn_level, btn_press, btn_release, btn_long} !== {m_level, m_press, m_release, m_long}) begin
            fails++;
            $display("FAIL model_cycle t=%0t got lvl/prs/rel/lng=%b required=%b", $time,
                     {btn_level, btn_press, btn_release, btn_long}, {m_level, m_press, m_release, m_long});
        end
        tests++;
        if (btn_press && btn_release) begin
            fails++;
            $display("FAIL press_release_overlap t=%0t got both=1 required not both", $time);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got %0d required %0d", name, $time, got, exp);
        end
    endtask

    // Returns the number of negedges until sig_sel fires (0 = press, 1 = long), or -1 on timeout.
    task automatic wait_pulse(input int sig_sel, input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((sig_sel == 0 && btn_press) || (sig_sel == 1 && btn_long)) begin
                k = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic pin;
        int   cycles;
        logic lvl;
        int   np;
        int   nr;
        int   nl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic pin, input int cycles, input logic lvl,
                                input int np, input int nr, input int nl);
        vec_t v;
        v.pin = pin; v.cycles = cycles; v.lvl = lvl; v.np = np; v.nr = nr; v.nl = nl;
        return v;
    endfunction

    initial begin
        int k, np, nr, nl;

        tbl.push_back(mk(1'b1, 50, 1'b0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(1'b0, 2, 1'b0, 0, 0, 0));
            tbl.push_back(mk(1'b1, 2, 1'b0, 0, 0, 0));
        end
        tbl.push_back(mk(1'b0, 10, 1'b1, 1, 0, 0));
        tbl.push_back(mk(1'b1,  3, 1'b1, 0, 0, 0));
        tbl.push_back(mk(1'b0,  2, 1'b1, 0, 0, 0));
        tbl.push_back(mk(1'b1, 10, 1'b0, 0, 1, 0));
        tbl.push_back(mk(1'b0, 30, 1'b1, 1, 0, 1));
        tbl.push_back(mk(1'b0, 20, 1'b1, 0, 0, 0));
        tbl.push_back(mk(1'b1, 10, 1'b0, 0, 1, 0));
        tbl.push_back(mk(1'b0, 30, 1'b1, 1, 0, 1));
        tbl.push_back(mk(1'b1, 10, 1'b0, 0, 1, 0));

        repeat (3) @(negedge clk);
        check("reset_level", int'(btn_level), 0);
        check("reset_pulses", int'({btn_press, btn_release, btn_long}), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            btn_in = tbl[i].pin;
            np = 0; nr = 0; nl = 0;
            repeat (tbl[i].cycles) begin
                @(negedge clk);
                np += int'(btn_press);
                nr += int'(btn_release);
                nl += int'(btn_long);
            end
            check($sformatf("vec%0d_level", i), int'(btn_level), int'(tbl[i].lvl));
            check($sformatf("vec%0d_press", i), np, tbl[i].np);
            check($sformatf("vec%0d_release", i), nr, tbl[i].nr);
            check($sformatf("vec%0d_long", i), nl, tbl[i].nl);
        end

        // Exact press latency and long-press timing from a clean edge.
        btn_in = 1'b0;
        wait_pulse(0, 40, k);
        check("press_latency", k, DC + 2);
        wait_pulse(1, 40, k);
        check("long_delay", k, LC);
        np = 0; nl = 0;
        repeat (30) begin
            @(negedge clk);
            np += int'(btn_press);
            nl += int'(btn_long);
        end
        check("no_extra_long", nl, 0);
        check("no_extra_press", np, 0);

        // Reset while held, then re-debounce after reset release.
        #2 rst_n = 1'b0;
        #1;
        check("midreset_level", int'(btn_level), 0);
        check("midreset_pulses", int'({btn_press, btn_release, btn_long}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_pulse(0, 40, k);
        check("post_reset_press", k, DC + 2);
        check("post_reset_level", int'(btn_level), 1);
        btn_in = 1'b1;
        repeat (15) @(negedge clk);
        check("final_release_level", int'(btn_level), 0);

        for (int i = 0; i < 80; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, (i % 4 == 0) ? 30 : 7)) @(negedge clk);
        end
        btn_in = 1'b1;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
